// File: rtl/ula_pkg.sv
// Shared types for the ULA arbiter slice: opcode and response-state enums,
// default datapath widths.
// Optional build macro: ULA_ARB_SATURATE_EN (saturating ADD/SUB results).
package ula_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } ula_op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ula_core.sv
// Combinational signed ALU: AND / OR / ADD / SUB with overflow flag.
// Build macro ULA_ARB_SATURATE_EN clamps overflowing ADD/SUB results to the
// signed range limits; otherwise results wrap modulo 2^N.
module ula_core
  import ula_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] s,
  output logic         flag
);

  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic [N-1:0] wrapped;
  logic         sign_a;
  logic         sign_b;

  assign sum    = a + b;
  assign diff   = a - b;
  assign sign_a = a[N-1];
  assign sign_b = b[N-1];

  // Select the operation and derive the signed overflow flag.
  always_comb begin
    wrapped = '0;
    flag    = 1'b0;
    unique case (ula_op_t'(op))
      OP_AND: wrapped = a & b;
      OP_OR:  wrapped = a | b;
      OP_ADD: begin
        wrapped = sum;
        flag    = (sign_a == sign_b) && (sum[N-1] != sign_a);
      end
      OP_SUB: begin
        wrapped = diff;
        flag    = (sign_a != sign_b) && (diff[N-1] != sign_a);
      end
      default: ;
    endcase
  end

`ifdef ULA_ARB_SATURATE_EN
  // On overflow the true result always carries the sign of A, so A's sign
  // picks the clamp limit.
  always_comb begin
    s = wrapped;
    if (flag) begin
      s = sign_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign s = wrapped;
`endif

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for a shared signed ALU. One request is
// accepted per cycle into a single result register that is presented on a
// valid/ready response channel tagged with the requester ID. Also keeps a
// saturating count of overflowing operations.
// Build macro ULA_ARB_SATURATE_EN is forwarded to ula_core (saturating results).
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_s,
  output logic             rsp_flag_o,
  output logic             rsp_id,
  output logic [CNT_W-1:0] ovf_count
);

  arb_state_t   state;
  logic         last_grant;
  logic         grant;
  logic         can_accept;
  logic         accept;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [1:0]   sel_op;
  logic [N-1:0] core_s;
  logic         core_flag;

  // Round-robin pick: a lone requester wins, a tie goes to the one not
  // granted last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // A result being drained this cycle frees the register for a new accept.
  assign can_accept = !reset && ((state == EMPTY) || (rsp_valid && rsp_ready));
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;
  assign sel_op = grant ? req1_op : req0_op;

  ula_core #(
    .N(N)
  ) u_core (
    .a    (sel_a),
    .b    (sel_b),
    .op   (sel_op),
    .s    (core_s),
    .flag (core_flag)
  );

  // Response FSM: load the result on accept, release it on drain; also
  // track the last grant and count overflowing accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_s      <= '0;
      rsp_flag_o <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      ovf_count  <= '0;
    end else begin
      if (accept) begin
        state      <= FULL;
        rsp_valid  <= 1'b1;
        rsp_s      <= core_s;
        rsp_flag_o <= core_flag;
        rsp_id     <= grant;
        last_grant <= grant;
        if (core_flag && (ovf_count != '1)) begin
          ovf_count <= ovf_count + CNT_W'(1);
        end
      end else if (rsp_valid && rsp_ready) begin
        state     <= EMPTY;
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter: stimulus pushes hand-computed expected
// responses, a monitor pops and compares on each response handshake.
module tb_ula_arbiter;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready;
  logic [N-1:0]     rsp_s;
  logic             rsp_flag_o, rsp_id;
  logic [CNT_W-1:0] ovf_count;

  typedef struct {
    logic [N-1:0]     s;
    logic             flag;
    logic             id;
    logic [CNT_W-1:0] ovf;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ula_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_s      (rsp_s),
    .rsp_flag_o (rsp_flag_o),
    .rsp_id     (rsp_id),
    .ovf_count  (ovf_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] s, input logic flag, input logic id,
                      input logic [CNT_W-1:0] ovf, input string name);
    exp_t e;
    e.s = s; e.flag = flag; e.id = id; e.ovf = ovf; e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, check the readies, then advance past the edge.
  task automatic step(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                      input logic [1:0] op0, input logic v1, input logic [N-1:0] a1,
                      input logic [N-1:0] b1, input logic [1:0] op1, input logic rr,
                      input logic er0, input logic er1, input string name);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr;
    #1;
    chk({name, " req0_ready"}, 32'(req0_ready), 32'(er0));
    chk({name, " req1_ready"}, 32'(req1_ready), 32'(er1));
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare the presented response whenever it is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got s=0x%0h id=%0d, expected no response", rsp_s, rsp_id);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, " rsp_s"},     32'(rsp_s),      32'(e.s));
          chk({e.name, " rsp_flag"},  32'(rsp_flag_o), 32'(e.flag));
          chk({e.name, " rsp_id"},    32'(rsp_id),     32'(e.id));
          chk({e.name, " ovf_count"}, 32'(ovf_count),  32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_s",     32'(rsp_s), 0);
    chk("reset rsp_flag",  32'(rsp_flag_o), 0);
    chk("reset rsp_id",    32'(rsp_id), 0);
    chk("reset ovf_count", 32'(ovf_count), 0);
    chk("reset req0_ready", 32'(req0_ready), 0);
    chk("reset req1_ready", 32'(req1_ready), 0);
    reset = 1'b0;

    // Overflow wrap: 100 + 50
`ifdef ULA_ARB_SATURATE_EN
    push(8'h7F, 1'b1, 1'b0, 16'd1, "add_ovf");
`else
    push(8'h96, 1'b1, 1'b0, 16'd1, "add_ovf");
`endif
    step(1, 8'd100, 8'd50, 2'b10, 0, 8'h00, 8'h00, 2'b00, 1, 1, 0, "add_ovf");

    // Underflow: -128 - 1 from req1
`ifdef ULA_ARB_SATURATE_EN
    push(8'h80, 1'b1, 1'b1, 16'd2, "sub_unf");
`else
    push(8'h7F, 1'b1, 1'b1, 16'd2, "sub_unf");
`endif
    step(0, 8'h00, 8'h00, 2'b00, 1, 8'h80, 8'h01, 2'b11, 1, 0, 1, "sub_unf");

    // Logic ops
    push(8'h0C, 1'b0, 1'b0, 16'd2, "and");
    step(1, 8'h0F, 8'h3C, 2'b00, 0, 8'h00, 8'h00, 2'b00, 1, 1, 0, "and");
    push(8'h3F, 1'b0, 1'b1, 16'd2, "or");
    step(0, 8'h00, 8'h00, 2'b00, 1, 8'h0F, 8'h30, 2'b01, 1, 0, 1, "or");

    // Tie alternation: req0 ADD k+1, req1 SUB k-1
    push(8'd2, 1'b0, 1'b0, 16'd2, "tie1");
    step(1, 8'd1, 8'd1, 2'b10, 1, 8'd1, 8'd1, 2'b11, 1, 1, 0, "tie1");
    push(8'd1, 1'b0, 1'b1, 16'd2, "tie2");
    step(1, 8'd2, 8'd1, 2'b10, 1, 8'd2, 8'd1, 2'b11, 1, 0, 1, "tie2");
    push(8'd4, 1'b0, 1'b0, 16'd2, "tie3");
    step(1, 8'd3, 8'd1, 2'b10, 1, 8'd3, 8'd1, 2'b11, 1, 1, 0, "tie3");
    push(8'd3, 1'b0, 1'b1, 16'd2, "tie4");
    step(1, 8'd4, 8'd1, 2'b10, 1, 8'd4, 8'd1, 2'b11, 1, 0, 1, "tie4");

    // Backpressure: hold 5+5 for 5 cycles with both requesters waiting
    push(8'd10, 1'b0, 1'b0, 16'd2, "bp_held");
    step(1, 8'd5, 8'd5, 2'b10, 0, 8'h00, 8'h00, 2'b00, 1, 1, 0, "bp_load");
    for (int i = 0; i < 5; i++) begin
      step(1, 8'd7, 8'd7, 2'b10, 1, 8'd20, 8'd5, 2'b11, 0, 0, 0, "bp_stall");
      chk("bp rsp_valid", 32'(rsp_valid), 1);
      chk("bp rsp_s",     32'(rsp_s), 10);
      chk("bp rsp_id",    32'(rsp_id), 0);
    end
    // Drain and accept in the same cycle; last grant was req0 so req1 wins
    push(8'd15, 1'b0, 1'b1, 16'd2, "bp_next");
    step(1, 8'd7, 8'd7, 2'b10, 1, 8'd20, 8'd5, 2'b11, 1, 0, 1, "bp_release");
    step(0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0, "drain");

    // Reset mid-operation: 100+100 accepted then dropped
    step(1, 8'd100, 8'd100, 2'b10, 0, 8'h00, 8'h00, 2'b00, 0, 1, 0, "pre_reset");
    chk("pre_reset rsp_valid", 32'(rsp_valid), 1);
    chk("pre_reset rsp_s",     32'(rsp_s), 32'h0C8 & 32'hFF ^
`ifdef ULA_ARB_SATURATE_EN
        (32'hC8 ^ 32'h7F)
`else
        32'h0
`endif
    );
    chk("pre_reset ovf_count", 32'(ovf_count), 3);
    req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_reset rsp_valid", 32'(rsp_valid), 0);
    chk("mid_reset ovf_count", 32'(ovf_count), 0);
    chk("mid_reset req0_ready", 32'(req0_ready), 0);
    chk("mid_reset req1_ready", 32'(req1_ready), 0);
    @(posedge clk);
    #2;
    chk("in_reset rsp_valid", 32'(rsp_valid), 0);
    reset = 1'b0;

    // First tie after reset goes to req0
    push(8'h0F, 1'b0, 1'b0, 16'd0, "post_reset_tie");
    step(1, 8'hFF, 8'h0F, 2'b00, 1, 8'h01, 8'h02, 2'b01, 1, 1, 0, "post_reset_tie");
    step(0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0, "final_drain");
    repeat (2) @(posedge clk);
    #2;
    chk("end rsp_valid", 32'(rsp_valid), 0);
    chk("end queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares one N-bit signed ALU datapath (AND, OR, ADD, SUB with overflow flag) between two independent requesters. Each requester presents operands and an opcode on a valid/ready channel. A round-robin arbiter grants one request per cycle, and the registered result is returned on a single valid/ready response channel tagged with the requester ID. The block sits between the two issuing units and the shared ALU, and also keeps a saturating count of overflow events.

## Interface
- `N`, 8, operand/result width in bits (signed two's complement)
- `CNT_W`, 16, width of the overflow event counter
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (valid && ready)
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  N  signed operands
- `req0_op`, `req1_op`  in  2  opcode: 00 AND, 01 OR (bitwise), 10 ADD, 11 SUB (A−B)
- `rsp_valid`  out  1  result register holds a result
- `rsp_ready`  in  1  consumer takes the result
- `rsp_s`  out  N  signed result
- `rsp_flag_o`  out  1  overflow/underflow of the operation
- `rsp_id`  out  1  requester that issued the result (0/1)
- `ovf_count`  out  CNT_W  number of accepted ops with overflow, saturating

## Operation
- States: EMPTY (no result held) and FULL (result held, `rsp_valid`=1).
- can_accept = EMPTY || (rsp_valid && rsp_ready), so a drained result allows a new accept in the same cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last time wins.
  - `last_grant` updates only on an actual accept.
- `reqX_ready` = can_accept && grant==X. Ready is never asserted for a non-granted requester. Ready may depend combinationally on both valids and `rsp_ready`.
- On accept: compute S and flag from the granted operands, load `rsp_s`, `rsp_flag_o`, `rsp_id`, and go to FULL. Otherwise, on `rsp_valid && rsp_ready`, go to EMPTY.
- Arithmetic:
  - Results wrap modulo 2^N.
  - ADD flag = (sign A == sign B) && (sign S != sign A).
  - SUB flag = (sign A != sign B) && (sign S != sign A).
  - AND/OR flag = 0; OR is bitwise.
- `ovf_count` increments on each accepted op with flag=1 and holds at 2^CNT_W−1.

## Timing
- Latency: the result appears 1 cycle after the accept edge.
- Throughput: 1 op/cycle while `rsp_ready`=1.
- Reset values: `rsp_valid`=0, `rsp_s`=0, `rsp_flag_o`=0, `rsp_id`=0, `ovf_count`=0, state EMPTY, `last_grant`=1 (req0 wins the first tie).
- `reqX_ready` is 0 while `reset` is high.
- Response outputs stay stable while `rsp_valid && !rsp_ready`.
- Reset asserted mid-operation drops the pending result immediately (asynchronous). No result is produced for a request accepted in the reset cycle.
- Requester inputs are sampled only on the accept edge. Changing them afterwards has no effect on the result.

## Configuration
- Macro `ULA_ARB_SATURATE_EN`.
- Defined: an ADD/SUB with flag=1 returns 2^(N−1)−1 when the true result is positive and −2^(N−1) when it is negative. The flag is still reported and counted.
- Undefined: wrapped result, as above.
- AND/OR are identical in both builds.

## Structure
- Package `ula_pkg`:
  - opcode enum `ula_op_t` (OP_AND, OP_OR, OP_ADD, OP_SUB)
  - state enum `arb_state_t` (EMPTY, FULL)
  - `N` default
- Sub-module `ula_core`: purely combinational A/B/op → S/flag, including the saturation option. The arbiter and result register live in `ula_arbiter`.

## Test plan
- **Overflow wrap:** N=8, req0 ADD 100+50 → next cycle `rsp_s`=−106, `rsp_flag_o`=1, `rsp_id`=0, `ovf_count`=1. With `ULA_ARB_SATURATE_EN`, `rsp_s`=127.
- **Underflow:** req1 SUB −128−1 → `rsp_s`=127, flag=1, `rsp_id`=1. Saturated build: −128.
- **Tie alternation:** both valid every cycle with `rsp_ready`=1 → grants 0,1,0,1. `rsp_id` follows the same sequence, one per cycle.
- **Backpressure:** `rsp_ready`=0 with a result held → both readies 0 and `rsp_s`/`rsp_id` stable for 5 cycles. Raising `rsp_ready` drains the result and accepts the next request in the same cycle.
- **Logic ops:** AND 0x0F&0x3C → 0x0C, flag 0. OR 0x0F|0x30 → 0x3F, flag 0. `ovf_count` unchanged.
- **Reset mid-operation:** assert `reset` while FULL → `rsp_valid`=0 and `ovf_count`=0 immediately. After release, first tie goes to req0.
